// File: rtl/ifm_rd_pkg.sv
// Shared definitions for the IFM BRAM read sequencer: FSM state encoding,
// default widths and the word size in bytes.
package ifm_rd_pkg;

  localparam int ADDR_W_DEF     = 20;
  localparam int DATA_W_DEF     = 32;
  localparam int CNT_W_DEF      = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/ifm_bram_reader_if.sv
// Valid/ready word stream from the IFM reader to the convolution datapath.
// m_last marks the final word of a tile and is qualified by m_valid.
interface ifm_bram_reader_if
  import ifm_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/ifm_rd_fifo2.sv
// Two-entry FIFO with an empty-bypass path: when empty, an incoming word is
// presented on the output in the same cycle and only stored if not taken.
// o_count reports stored entries so the issuer can budget its reads.
module ifm_rd_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  input  logic         i_out_ready,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty     = (r_count == 2'd0);
  assign o_out_valid = !w_empty || i_in_valid;
  assign o_out_data  = !w_empty ? r_mem[r_rd_ptr] : (i_in_valid ? i_in_data : '0);
  assign w_pop       = !w_empty && i_out_ready;
  // A word that bypasses an empty FIFO and is accepted is never stored.
  assign w_push      = i_in_valid && !(w_empty && i_out_ready);
  assign o_count     = r_count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; r_count gates every read, so
    // stale contents are never observed and the array maps to plain flops/LUTRAM.
    if (w_push) r_mem[r_wr_ptr] <= i_in_data;
  end

endmodule

// File: rtl/ifm_bram_reader.sv
// Read-side sequencer for the IFM buffer BRAM. Walks a num_rows x row_words
// tile in row-major order, drives byte addresses, absorbs the 1-cycle BRAM
// latency and streams the words out through a 2-entry FIFO.
// Optional feature: define IFM_RD_BOUNDS_CHK_EN to zero out-of-range reads
// and raise the sticky oob_err flag.
module ifm_bram_reader
  import ifm_rd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
`ifdef IFM_RD_BOUNDS_CHK_EN
  , parameter int MEM_WORDS = 100353
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [CNT_W-1:0]  row_words,
  input  logic [CNT_W-1:0]  num_rows,
  output logic [ADDR_W-1:0] bram_rd_addr,
  input  logic [DATA_W-1:0] bram_rd_data,
  ifm_bram_reader_if.master m_axis,
  output logic              busy,
  output logic              done
`ifdef IFM_RD_BOUNDS_CHK_EN
  , output logic            oob_err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ST_ISSUE);
  localparam logic [1:0] S_DRAIN = 2'(ST_DRAIN);
  localparam logic [1:0] S_DONE  = 2'(ST_DONE);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_stride;
  logic [CNT_W-1:0]  r_col;
  logic [CNT_W-1:0]  r_row;
  logic [CNT_W-1:0]  r_row_words;
  logic [CNT_W-1:0]  r_num_rows;
  logic              r_empty;
  // Read pipeline: stage 1 = address on the BRAM port, stage 2 = data back.
  logic              r_pend1, r_pend1_last;
  logic              r_pend2, r_pend2_last;

  logic              w_accept, w_zero, w_start_last;
  logic              w_col_wrap, w_next_last;
  logic [CNT_W-1:0]  w_next_col, w_next_row;
  logic [ADDR_W-1:0] w_next_addr, w_next_row_base;
  logic [ADDR_W-1:0] w_iss_addr, w_iss_row_base;
  logic [CNT_W-1:0]  w_iss_col, w_iss_row;
  logic              w_iss_last, w_issue, w_credit, w_hs;
  logic [DATA_W-1:0] w_rd_data;
  logic [1:0]        w_count;
  logic              w_out_valid;
  logic [DATA_W:0]   w_out_data;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_zero       = (row_words == '0) || (num_rows == '0);
  assign w_start_last = (row_words == CNT_W'(1)) && (num_rows == CNT_W'(1));

  // Position of the read following the one currently on the BRAM port.
  always_comb begin
    // NOTE: every signal assigned here gets an unconditional value first so
    // no path leaves it unassigned and no latch is inferred.
    w_col_wrap      = (r_col == r_row_words - CNT_W'(1));
    w_next_col      = r_col + CNT_W'(1);
    w_next_row      = r_row;
    w_next_row_base = r_row_base;
    w_next_addr     = r_addr + ADDR_W'(BYTES_PER_WORD);
    if (w_col_wrap) begin
      w_next_col      = '0;
      w_next_row      = r_row + CNT_W'(1);
      w_next_row_base = r_row_base + r_stride;
      w_next_addr     = r_row_base + r_stride;
    end
    w_next_last = (w_next_col == r_row_words - CNT_W'(1)) &&
                  (w_next_row == r_num_rows - CNT_W'(1));
  end

  // The first read goes out on the start edge; later ones come from the walker.
  assign w_iss_addr     = w_accept ? base_addr : w_next_addr;
  assign w_iss_row_base = w_accept ? base_addr : w_next_row_base;
  assign w_iss_col      = w_accept ? '0 : w_next_col;
  assign w_iss_row      = w_accept ? '0 : w_next_row;
  assign w_iss_last     = w_accept ? w_start_last : w_next_last;

  // Everything already committed (stored, arriving, on the address port) must
  // fit in the FIFO if m_ready stays low; a beat leaving this cycle frees a slot.
  assign w_hs     = w_out_valid && m_axis.m_ready;
  assign w_credit = (3'(w_count) + 3'(r_pend1) + 3'(r_pend2)) < (3'd2 + 3'(w_hs));
  assign w_issue  = (w_accept && !w_zero) || ((r_state == S_ISSUE) && w_credit);

  // Tile control: parameter latch, address walker and FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_row_base  <= '0;
      r_stride    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_row_words <= '0;
      r_num_rows  <= '0;
      r_empty     <= 1'b0;
    end else begin
      if (w_issue) begin
        r_addr     <= w_iss_addr;
        r_row_base <= w_iss_row_base;
        r_col      <= w_iss_col;
        r_row      <= w_iss_row;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_stride    <= row_stride;
          r_row_words <= row_words;
          r_num_rows  <= num_rows;
          r_empty     <= w_zero;
          // An empty tile spends one cycle in DRAIN so done lands two cycles
          // after start, with busy high for that one cycle.
          r_state     <= (w_zero || w_start_last) ? S_DRAIN : S_ISSUE;
        end
        S_ISSUE: if (w_issue && w_next_last) r_state <= S_DRAIN;
        S_DRAIN: if (r_empty || (w_hs && m_axis.m_last)) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Track which BRAM cycles carry a requested word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend1      <= 1'b0;
      r_pend1_last <= 1'b0;
      r_pend2      <= 1'b0;
      r_pend2_last <= 1'b0;
    end else begin
      r_pend1      <= w_issue;
      r_pend1_last <= w_issue && w_iss_last;
      r_pend2      <= r_pend1;
      r_pend2_last <= r_pend1_last;
    end
  end

`ifdef IFM_RD_BOUNDS_CHK_EN
  logic r_pend1_oob, r_pend2_oob, r_oob_err;
  logic w_iss_oob;

  assign w_iss_oob = 64'(w_iss_addr >> $clog2(BYTES_PER_WORD)) >= 64'(MEM_WORDS);
  assign w_rd_data = r_pend2_oob ? '0 : bram_rd_data;
  assign oob_err   = r_oob_err;

  // Out-of-range tagging along the read pipeline plus the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend1_oob <= 1'b0;
      r_pend2_oob <= 1'b0;
      r_oob_err   <= 1'b0;
    end else begin
      r_pend1_oob <= w_issue && w_iss_oob;
      r_pend2_oob <= r_pend1_oob;
      if (w_accept)                   r_oob_err <= w_issue && w_iss_oob;
      else if (w_issue && w_iss_oob)  r_oob_err <= 1'b1;
    end
  end
`else
  assign w_rd_data = bram_rd_data;
`endif

  ifm_rd_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (r_pend2),
    .i_in_data   ({r_pend2_last, w_rd_data}),
    .o_out_valid (w_out_valid),
    .o_out_data  (w_out_data),
    .i_out_ready (m_axis.m_ready),
    .o_count     (w_count)
  );

  assign m_axis.m_valid = w_out_valid;
  assign m_axis.m_data  = w_out_data[DATA_W-1:0];
  assign m_axis.m_last  = w_out_data[DATA_W];
  assign bram_rd_addr   = r_addr;
  assign busy           = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done           = (r_state == S_DONE);

endmodule
